// File: rtl/adc_clk_pkg.sv
// Shared types and sizing helpers for the ADC clock PLL supervisor.
package adc_clk_pkg;

  localparam int unsigned LOCK_LOSS_CNT_W = 16;

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } state_e;

  // Phase counter must hold the largest of the three cycle limits without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned retry_width(input int unsigned max_retries);
    return (max_retries > 0) ? $clog2(max_retries + 1) : 1;
  endfunction

endpackage

// File: rtl/adc_pll_supervisor_if.sv
// PLL control/status bundle between the supervisor and the PLL wrapper / ADC logic.
// lock_loss_cnt is present only when LOCK_LOSS_CNT_EN is defined.
interface adc_pll_supervisor_if
  import adc_clk_pkg::*;
#(
  parameter int unsigned RETRY_W = 2
);
  logic               pll_locked;
  logic               restart;
  logic               pll_rst;
  logic               adc_rst;
  logic               clk_ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         state_o;
`ifdef LOCK_LOSS_CNT_EN
  logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt;
`endif

  modport master (
    input  pll_locked,
    input  restart,
    output pll_rst,
    output adc_rst,
    output clk_ready,
    output fault,
    output retry_cnt,
`ifdef LOCK_LOSS_CNT_EN
    output lock_loss_cnt,
`endif
    output state_o
  );

  modport slave (
    output pll_locked,
    output restart,
    input  pll_rst,
    input  adc_rst,
    input  clk_ready,
    input  fault,
    input  retry_cnt,
`ifdef LOCK_LOSS_CNT_EN
    input  lock_loss_cnt,
`endif
    input  state_o
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/adc_pll_supervisor.sv
// ADC clock PLL supervisor: reset pulse, lock wait, stability qualification, retry and fault.
// Optional lock-loss event counter enabled by defining LOCK_LOSS_CNT_EN.
module adc_pll_supervisor
  import adc_clk_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input logic                  refclk,
  input logic                  rst,
  adc_pll_supervisor_if.master bus
);

  localparam int unsigned CNT_W   = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                              LOCK_TIMEOUT_CYCLES);
  localparam int unsigned RETRY_W = retry_width(MAX_RETRIES);

  localparam logic [CNT_W-1:0]   PllRstLast  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RetryMax    = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, adc_rst_q, clk_ready_q, fault_q;
  logic               pll_rst_d, adc_rst_d, clk_ready_d, fault_d;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (lock_s)
  );

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    if (bus.restart) begin
      state_d = StPllRst;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (cnt_q == PllRstLast) state_d = StWaitLock;
          else                     cnt_d   = cnt_inc;
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
          end else if (cnt_q == TimeoutLast) begin
            if (retry_q == RetryMax) begin
              state_d = StFault;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = StPllRst;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StStable: begin
          // A single unlocked cycle drops back to waiting without costing an attempt.
          if (!lock_s) begin
            state_d = StWaitLock;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
            retry_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StRun: begin
          if (!lock_s) state_d = StPllRst;
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StPllRst;
        end
      endcase
    end

    if (bus.restart || (state_d != state_q)) cnt_d = '0;
  end

  // Outputs are decoded from the next state so the registered copies track state_q exactly.
  always_comb begin
    pll_rst_d   = (state_d == StPllRst) || (state_d == StFault);
    adc_rst_d   = (state_d != StRun);
    clk_ready_d = (state_d == StRun);
    fault_d     = (state_d == StFault);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= StPllRst;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      adc_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      adc_rst_q   <= adc_rst_d;
      clk_ready_q <= clk_ready_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.adc_rst   = adc_rst_q;
  assign bus.clk_ready = clk_ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state_o   = state_q;

`ifdef LOCK_LOSS_CNT_EN
  logic                       lock_loss;
  logic [LOCK_LOSS_CNT_W-1:0] loss_cnt_q;

  // restart takes precedence, so a simultaneous unlock is not a lock-loss event.
  assign lock_loss = (state_q == StRun) && !lock_s && !bus.restart;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if (lock_loss && (loss_cnt_q != {LOCK_LOSS_CNT_W{1'b1}})) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_adc_pll_supervisor.sv
// Randomized bench for adc_pll_supervisor against a time-in-phase reference model.
module tb_adc_pll_supervisor;

  localparam int unsigned P = 4;
  localparam int unsigned S = 8;
  localparam int unsigned T = 32;
  localparam int unsigned M = 2;

  localparam int ModePllRst = 0;
  localparam int ModeWait   = 1;
  localparam int ModeStable = 2;
  localparam int ModeRun    = 3;
  localparam int ModeFault  = 4;

  logic refclk = 1'b0;
  logic rst;

  always #5 refclk = ~refclk;

  adc_pll_supervisor_if #(.RETRY_W(2)) bus ();

  adc_pll_supervisor #(
    .PLL_RST_CYCLES      (P),
    .LOCK_STABLE_CYCLES  (S),
    .LOCK_TIMEOUT_CYCLES (T),
    .MAX_RETRIES         (M)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: phase plus the edge index at which it was entered.
  int cyc;
  int m_mode;
  int m_entered;
  int m_retries;
  int m_loss;
  bit lock_hist [$];   // pll_locked samples, oldest first; lock_s is two samples behind

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode    = ModePllRst;
    m_entered = cyc - 1;
    m_retries = 0;
    m_loss    = 0;
    lock_hist = '{1'b0, 1'b0};
  endtask

  task automatic model_go(input int mode);
    m_mode    = mode;
    m_entered = cyc;
  endtask

  task automatic model_tick(input bit lk, input bit rs);
    bit ls;
    int n;
    ls = lock_hist[0];
    lock_hist.delete(0);
    lock_hist.push_back(lk);
    n = cyc - m_entered;   // cycles spent in the phase, including this one
    if (rs) begin
      model_go(ModePllRst);
      m_retries = 0;
    end else begin
      case (m_mode)
        ModePllRst: if (n == P) model_go(ModeWait);
        ModeWait: begin
          if (ls) model_go(ModeStable);
          else if (n == T) begin
            if (m_retries == M) model_go(ModeFault);
            else begin
              m_retries++;
              model_go(ModePllRst);
            end
          end
        end
        ModeStable: begin
          if (!ls) model_go(ModeWait);
          else if (n == S) begin
            model_go(ModeRun);
            m_retries = 0;
          end
        end
        ModeRun: begin
          if (!ls) begin
            model_go(ModePllRst);
            if (m_loss < 65535) m_loss++;
          end
        end
        default: ;
      endcase
    end
    cyc++;
  endtask

  function automatic bit timeout_next();
    return (m_mode == ModeWait) && ((cyc - m_entered) == T) && (m_retries == M)
           && !lock_hist[0];
  endfunction

  task automatic compare_all();
    check_eq("state_o",   bus.state_o,   m_mode);
    check_eq("pll_rst",   bus.pll_rst,   (m_mode == ModePllRst) || (m_mode == ModeFault));
    check_eq("adc_rst",   bus.adc_rst,   m_mode != ModeRun);
    check_eq("clk_ready", bus.clk_ready, m_mode == ModeRun);
    check_eq("fault",     bus.fault,     m_mode == ModeFault);
    check_eq("retry_cnt", bus.retry_cnt, m_retries);
`ifdef LOCK_LOSS_CNT_EN
    check_eq("lock_loss_cnt", bus.lock_loss_cnt, m_loss);
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit lk, input bit rs);
    bus.pll_locked = lk;
    bus.restart    = rs;
    @(posedge refclk);
    model_tick(lk, rs);
    @(negedge refclk);
    compare_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge refclk);
    @(negedge refclk);
    compare_all();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int guard;
    int seg_left;
    bit seg_val;
    bit rs;
    int r;

    rst            = 1'b1;
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b0;
    cyc            = 0;
    repeat (3) @(negedge refclk);
    model_reset();
    compare_all();
    rst = 1'b0;

    // Lock rises at cycle 10 and holds: reach RUN.
    repeat (10) cycle(1'b0, 1'b0);
    repeat (30) cycle(1'b1, 1'b0);

    // Lock loss in RUN, then relock.
    repeat (2) cycle(1'b0, 1'b0);
    repeat (30) cycle(1'b1, 1'b0);

    // One-cycle glitch after five stable cycles.
    cycle(1'b0, 1'b0);
    guard = 0;
    while (!(m_mode == ModeStable && (cyc - m_entered) == 5) && guard < 200) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    check_eq("reach_stable5", guard < 200, 1'b1);
    cycle(1'b0, 1'b0);
    repeat (20) cycle(1'b1, 1'b0);

    // Never lock: three attempts then FAULT, then restart.
    repeat (140) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);

    // Restart landing exactly on the final timeout.
    guard = 0;
    while (!timeout_next() && guard < 200) begin
      cycle(1'b0, 1'b0);
      guard++;
    end
    check_eq("reach_last_timeout", guard < 200, 1'b1);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);

    // Asynchronous reset while in STABLE.
    guard = 0;
    while (m_mode != ModeStable && guard < 200) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    check_eq("reach_stable", guard < 200, 1'b1);
    cycle(1'b1, 1'b0);
    async_reset();

    // Randomized lock waveforms, restarts and resets.
    seg_left = 0;
    seg_val  = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (seg_left == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4) begin
          seg_val  = 1'b0;
          seg_left = $urandom_range(10, 150);
        end else if (r < 9) begin
          seg_val  = 1'b1;
          seg_left = $urandom_range(3, 60);
        end else begin
          seg_val  = 1'b0;
          seg_left = 1;
        end
      end
      rs = 1'b0;
      if (timeout_next() && ($urandom_range(0, 1) == 1)) rs = 1'b1;
      else if ($urandom_range(0, 249) == 0) rs = 1'b1;
      if (m_mode == ModeStable && $urandom_range(0, 59) == 0) async_reset();
      else cycle(seg_val, rs);
      seg_left--;
    end

    bus.restart = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
